// File: rtl/spi_ctrl_pkg.sv
// Shared types and default timing for the SPI transaction controller.
package spi_ctrl_pkg;

    localparam int unsigned DEF_LEN_W         = 8;
    localparam int unsigned DEF_CS_SETUP_CLKS = 2;
    localparam int unsigned DEF_CS_HOLD_CLKS  = 2;
    localparam int unsigned DEF_CS_IDLE_CLKS  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        WAIT_RX,
        CS_HOLD,
        CS_IDLE
    } state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_transaction_ctrl.sv
// Sequences a multi-byte SPI transaction around an external byte engine:
// CS setup/hold/idle timing, host byte handshake, one byte in flight, abort.
module spi_transaction_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W         = DEF_LEN_W,
    parameter int unsigned CS_SETUP_CLKS = DEF_CS_SETUP_CLKS,
    parameter int unsigned CS_HOLD_CLKS  = DEF_CS_HOLD_CLKS,
    parameter int unsigned CS_IDLE_CLKS  = DEF_CS_IDLE_CLKS
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic [LEN_W-1:0] i_Len,
    input  logic             i_Abort,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Aborted,
    input  logic [7:0]       i_Host_TX_Byte,
    input  logic             i_Host_TX_Valid,
    output logic             o_Host_TX_Ready,
    output logic [7:0]       o_Host_RX_Byte,
    output logic             o_Host_RX_DV,
    output logic [7:0]       o_TX_Byte,
    output logic             o_TX_DV,
    input  logic             i_TX_Ready,
    input  logic [7:0]       i_RX_Byte,
    input  logic             i_RX_DV,
    output logic             o_SPI_CS_n
);

    // All three delay parameters must be at least 1.
    localparam int unsigned MAX_CLKS = max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS);
    localparam int unsigned CNT_W    = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP_CLKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD_CLKS - 1);
    localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE_CLKS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             abort_q, abort_nxt;
    logic             cs_n_nxt, busy_nxt, done_nxt, aborted_nxt;
    logic             tx_dv_nxt, rx_dv_nxt;
    logic [7:0]       tx_byte_nxt, rx_byte_nxt;
    logic             host_ready_c;

    // The handshake is combinational so the host sees its byte taken in the same cycle.
    assign o_Host_TX_Ready = host_ready_c;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state          <= IDLE;
            cnt            <= '0;
            remaining      <= '0;
            abort_q        <= 1'b0;
            o_SPI_CS_n     <= 1'b1;
            o_Busy         <= 1'b0;
            o_Done         <= 1'b0;
            o_Aborted      <= 1'b0;
            o_TX_DV        <= 1'b0;
            o_TX_Byte      <= 8'h00;
            o_Host_RX_DV   <= 1'b0;
            o_Host_RX_Byte <= 8'h00;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            remaining      <= remaining_nxt;
            abort_q        <= abort_nxt;
            o_SPI_CS_n     <= cs_n_nxt;
            o_Busy         <= busy_nxt;
            o_Done         <= done_nxt;
            o_Aborted      <= aborted_nxt;
            o_TX_DV        <= tx_dv_nxt;
            o_TX_Byte      <= tx_byte_nxt;
            o_Host_RX_DV   <= rx_dv_nxt;
            o_Host_RX_Byte <= rx_byte_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        remaining_nxt = remaining;
        abort_nxt     = abort_q;
        cs_n_nxt      = o_SPI_CS_n;
        busy_nxt      = o_Busy;
        done_nxt      = 1'b0;
        aborted_nxt   = 1'b0;
        tx_dv_nxt     = 1'b0;
        tx_byte_nxt   = o_TX_Byte;
        rx_dv_nxt     = 1'b0;
        rx_byte_nxt   = o_Host_RX_Byte;
        host_ready_c  = 1'b0;

        case (state)
            IDLE: begin
                if (i_Start) begin
                    if (i_Len != '0) begin
                        remaining_nxt = i_Len;
                        abort_nxt     = 1'b0;
                        busy_nxt      = 1'b1;
                        cs_n_nxt      = 1'b0;
                        cnt_nxt       = SETUP_LD;
                        state_nxt     = CS_SETUP;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end

            CS_SETUP: begin
                if (i_Abort) begin
                    abort_nxt = 1'b1;
                    cnt_nxt   = HOLD_LD;
                    state_nxt = CS_HOLD;
                end else if (cnt == '0) begin
                    state_nxt = LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            // An abort wins over a same-cycle handshake so no host byte is silently dropped.
            LOAD: begin
                if (i_Abort) begin
                    abort_nxt = 1'b1;
                    cnt_nxt   = HOLD_LD;
                    state_nxt = CS_HOLD;
                end else begin
                    host_ready_c = i_Host_TX_Valid & i_TX_Ready;
                    if (host_ready_c) begin
                        tx_byte_nxt = i_Host_TX_Byte;
                        tx_dv_nxt   = 1'b1;
                        state_nxt   = WAIT_RX;
                    end
                end
            end

            WAIT_RX: begin
                if (i_Abort) begin
                    abort_nxt = 1'b1;
                end
                if (i_RX_DV) begin
                    rx_byte_nxt   = i_RX_Byte;
                    rx_dv_nxt     = 1'b1;
                    remaining_nxt = (remaining != '0) ? remaining - LEN_W'(1) : '0;
                    if (i_Abort || abort_q || (remaining_nxt == '0)) begin
                        cnt_nxt   = HOLD_LD;
                        state_nxt = CS_HOLD;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end

            CS_HOLD: begin
                if (cnt == '0) begin
                    cs_n_nxt  = 1'b1;
                    cnt_nxt   = IDLE_LD;
                    state_nxt = CS_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            CS_IDLE: begin
                if (cnt == '0) begin
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    aborted_nxt = abort_q;
                    abort_nxt   = 1'b0;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                cs_n_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
